// File: rtl/prog_loader.sv
// Boot-time program loader: streams header, instruction bytes and checksum
// into instruction memory, holding the CPU until a verified load completes.
module prog_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [8:0]      MAX_N = 9'(1 << ADDR_W);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

    state_t          state;
    state_t          state_n;
    logic [ADDR_W:0] cnt;
    logic [ADDR_W:0] idx;
    logic [7:0]      sum;
    logic            xfer;
    logic            hdr_bad;
    logic            last;

    assign in_ready = (state == S_HDR) || (state == S_DATA) ||
                      (state == S_CSUM);
    assign xfer     = in_valid & in_ready;
    assign hdr_bad  = (in_data == 8'd0) || ({1'b0, in_data} > MAX_N);
    assign last     = (idx == cnt - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (load_req) state_n = S_HDR;
            S_HDR: begin
                if (xfer) state_n = hdr_bad ? S_ERR : S_DATA;
            end
            S_DATA: if (xfer && last) state_n = S_CSUM;
            S_CSUM: begin
                if (xfer) state_n = (in_data == sum) ? S_DONE : S_ERR;
            end
            S_DONE: if (load_req) state_n = S_HDR;
            S_ERR:  if (load_req) state_n = S_HDR;
            default: state_n = S_IDLE;
        endcase
    end

    // Status flags are registered copies of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            cpu_hold <= (state_n != S_DONE);
            done     <= (state_n == S_DONE);
            err      <= (state_n == S_ERR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            idx          <= '0;
            sum          <= '0;
            words_loaded <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
        end else begin
            imem_we <= 1'b0;
            if (state == S_HDR && xfer && !hdr_bad) begin
                cnt          <= in_data[ADDR_W:0];
                idx          <= '0;
                sum          <= '0;
                words_loaded <= '0;
            end
            if (state == S_DATA && xfer) begin
                imem_we      <= 1'b1;
                imem_addr    <= idx[ADDR_W-1:0];
                imem_wdata   <= in_data;
                sum          <= sum + in_data;
                idx          <= idx + ONE;
                words_loaded <= words_loaded + ONE;
            end
        end
    end

endmodule
